// File: rtl/vsdmem_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge and its port arbiter.
package vsdmem_pkg;

  localparam int SRAM_AW   = 8;
  localparam int SRAM_DW   = 32;
  localparam int WIN_BYTES = 1024;
  localparam int WIN_LSB   = $clog2(WIN_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_WR_MERGE = 2'd2,
    ST_ACK      = 2'd3
  } bridge_state_e;

  // Byte-lane merge for read-modify-write: new lane where sel is set, old lane otherwise.
  function automatic logic [SRAM_DW-1:0] merge_lanes(
    input logic [SRAM_DW-1:0] wdata,
    input logic [SRAM_DW-1:0] old,
    input logic [3:0]         sel
  );
    logic [SRAM_DW-1:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_port_arb.sv
// Combinational SRAM port mux: the bridge owns the port when selected, the core otherwise.
module sram_port_arb
  import vsdmem_pkg::*;
#(
  parameter int AW = SRAM_AW
) (
  input  logic               bridge_sel,
  input  logic               core_csb,
  input  logic               core_web,
  input  logic [AW-1:0]      core_addr,
  input  logic [SRAM_DW-1:0] core_din,
  input  logic               br_csb,
  input  logic               br_web,
  input  logic [AW-1:0]      br_addr,
  input  logic [SRAM_DW-1:0] br_din,
  output logic               csb0,
  output logic               web0,
  output logic [AW-1:0]      addr0,
  output logic [SRAM_DW-1:0] din0
);

  // Select the SRAM port owner for this cycle.
  always_comb begin
    csb0  = core_csb;
    web0  = core_web;
    addr0 = core_addr;
    din0  = core_din;
    if (bridge_sel) begin
      csb0  = br_csb;
      web0  = br_web;
      addr0 = br_addr;
      din0  = br_din;
    end else begin
      csb0  = core_csb;
      web0  = core_web;
      addr0 = core_addr;
      din0  = core_din;
    end
  end

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone slave giving the bus priority access to a core-owned single-port SRAM,
// with byte-lane writes implemented as read-modify-write.
module wb_sram_bridge
  import vsdmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          AW        = SRAM_AW
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_dat_i,
  input  logic [31:0]        wbs_adr_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic               core_csb,
  input  logic               core_web,
  input  logic [AW-1:0]      core_addr,
  input  logic [SRAM_DW-1:0] core_din,
  output logic               core_stall,
  output logic               csb0,
  output logic               web0,
  output logic [AW-1:0]      addr0,
  output logic [SRAM_DW-1:0] din0,
  input  logic [SRAM_DW-1:0] dout0
);

  bridge_state_e      state;
  logic [SRAM_DW-1:0] rdata_q;
  logic               hit;
  logic               req;
  logic               full_wr;
  logic               br_csb;
  logic               br_web;
  logic [AW-1:0]      br_addr;
  logic [SRAM_DW-1:0] br_din;
  logic               unused_adr;

  // Reset gates acceptance so the core keeps the port while reset is held.
  assign hit        = (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
  assign req        = wb_rst_n & wbs_stb_i & wbs_cyc_i & hit;
  assign full_wr    = wbs_we_i & (wbs_sel_i == 4'hF);
  assign unused_adr = ^wbs_adr_i[1:0];

  // Bridge FSM and captured read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state   <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= full_wr ? ST_ACK : ST_RD_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (!wbs_cyc_i) begin
            state <= ST_IDLE;
          end else begin
            rdata_q <= dout0;
            state   <= wbs_we_i ? ST_WR_MERGE : ST_ACK;
          end
        end
        ST_WR_MERGE: state <= wbs_cyc_i ? ST_ACK : ST_IDLE;
        ST_ACK:      state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Bridge-side SRAM request and core stall for the current state.
  always_comb begin
    br_csb     = 1'b1;
    br_web     = 1'b1;
    br_addr    = wbs_adr_i[AW+1:2];
    br_din     = wbs_dat_i;
    core_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          core_stall = 1'b1;
          br_csb     = 1'b0;
          br_web     = ~full_wr;
        end else begin
          core_stall = 1'b0;
        end
      end
      ST_RD_WAIT: core_stall = 1'b1;
      ST_WR_MERGE: begin
        core_stall = 1'b1;
        br_csb     = ~wbs_cyc_i;
        br_web     = ~wbs_cyc_i;
        br_din     = merge_lanes(wbs_dat_i, rdata_q, wbs_sel_i);
      end
      ST_ACK:  core_stall = 1'b0;
      default: core_stall = 1'b0;
    endcase
  end

  // A master abandoning the cycle in ACK never sees the ack.
  assign wbs_ack_o = (state == ST_ACK) & wbs_cyc_i;
  assign wbs_dat_o = (wbs_ack_o & ~wbs_we_i) ? rdata_q : 32'h0;

  sram_port_arb #(.AW(AW)) u_arb (
    .bridge_sel (core_stall),
    .core_csb   (core_csb),
    .core_web   (core_web),
    .core_addr  (core_addr),
    .core_din   (core_din),
    .br_csb     (br_csb),
    .br_web     (br_web),
    .br_addr    (br_addr),
    .br_din     (br_din),
    .csb0       (csb0),
    .web0       (web0),
    .addr0      (addr0),
    .din0       (din0)
  );

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed self-checking bench for wb_sram_bridge with a behavioural synchronous SRAM.
module tb_wb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack;
  logic [31:0] dat_o;
  logic        core_csb, core_web;
  logic [7:0]  core_addr;
  logic [31:0] core_din;
  logic        core_stall;
  logic        csb0, web0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic [31:0] mem [256];
  logic        mem_clr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_sram_bridge #(.BASE_ADDR(32'h3000_0000), .AW(8)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .core_csb(core_csb), .core_web(core_web), .core_addr(core_addr), .core_din(core_din),
    .core_stall(core_stall),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
  );

  // SRAM model: synchronous write, registered read data valid the cycle after the request.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      dout0 <= 32'h0;
    end else if (!csb0) begin
      if (!web0) mem[addr0] <= din0;
      else       dout0 <= mem[addr0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic wb_drive(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
    stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; dat_i = d;
  endtask

  task automatic wb_release();
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; dat_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_clr = 1'b1;
    core_csb = 1'b0; core_web = 1'b1; core_addr = 8'h55; core_din = 32'h1234_5678;
    wb_drive(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    tick(); tick(); settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", ack); end
    checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 00000000", dat_o); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", core_stall); end
    checks++; if (csb0 !== 1'b0) begin errors++; $display("FAIL rst_csb0: got %b expected 0", csb0); end
    checks++; if (web0 !== 1'b1) begin errors++; $display("FAIL rst_web0: got %b expected 1", web0); end
    checks++; if (addr0 !== 8'h55) begin errors++; $display("FAIL rst_addr0: got %h expected 55", addr0); end
    checks++; if (din0 !== 32'h1234_5678) begin errors++; $display("FAIL rst_din0: got %h expected 12345678", din0); end
    tick(); wb_release(); core_csb = 1'b1; mem_clr = 1'b0; rst_n = 1'b1; settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_rel_ack: got %b expected 0", ack); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_rel_stall: got %b expected 0", core_stall); end
  endtask

  task automatic test_full_write();
    tick(); wb_drive(1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF); settle();
    checks++; if (csb0 !== 1'b0 || web0 !== 1'b0) begin errors++; $display("FAIL fw_n_ctrl: got csb0=%b web0=%b expected 0 0", csb0, web0); end
    checks++; if (addr0 !== 8'h04) begin errors++; $display("FAIL fw_n_addr: got %h expected 04", addr0); end
    checks++; if (din0 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fw_n_din: got %h expected deadbeef", din0); end
    checks++; if (core_stall !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL fw_n_stall_ack: got stall=%b ack=%b expected 1 0", core_stall, ack); end
    tick(); settle();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL fw_ack_n1: got %b expected 1", ack); end
    checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL fw_ack_dat: got %h expected 00000000", dat_o); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL fw_ack_stall: got %b expected 0", core_stall); end
    tick(); wb_release(); settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL fw_ack_once: got %b expected 0", ack); end
    checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fw_mem: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_read_with_core();
    core_csb = 1'b0; core_web = 1'b1;
    tick(); core_addr = 8'h20; settle();
    checks++; if (addr0 !== 8'h20 || csb0 !== 1'b0 || core_stall !== 1'b0) begin errors++; $display("FAIL rd_core_pass: got addr0=%h csb0=%b stall=%b expected 20 0 0", addr0, csb0, core_stall); end
    tick(); core_addr = 8'h21; wb_drive(1'b0, 4'hF, 32'h3000_0010, 32'h0); settle();
    checks++; if (core_stall !== 1'b1 || csb0 !== 1'b0 || web0 !== 1'b1) begin errors++; $display("FAIL rd_n: got stall=%b csb0=%b web0=%b expected 1 0 1", core_stall, csb0, web0); end
    checks++; if (addr0 !== 8'h04) begin errors++; $display("FAIL rd_n_addr: got %h expected 04", addr0); end
    tick(); core_addr = 8'h22; settle();
    checks++; if (core_stall !== 1'b1 || csb0 !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL rd_wait: got stall=%b csb0=%b ack=%b expected 1 1 0", core_stall, csb0, ack); end
    tick(); core_addr = 8'h23; settle();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rd_ack_n2: got %b expected 1", ack); end
    checks++; if (dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_dat: got %h expected deadbeef", dat_o); end
    checks++; if (core_stall !== 1'b0 || addr0 !== 8'h23 || csb0 !== 1'b0) begin errors++; $display("FAIL rd_ack_core: got stall=%b addr0=%h csb0=%b expected 0 23 0", core_stall, addr0, csb0); end
    tick(); wb_release(); core_addr = 8'h24; settle();
    checks++; if (ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL rd_after: got ack=%b dat=%h expected 0 00000000", ack, dat_o); end
    checks++; if (addr0 !== 8'h24) begin errors++; $display("FAIL rd_after_addr: got %h expected 24", addr0); end
    core_csb = 1'b1;
  endtask

  task automatic test_partial_write();
    tick(); wb_drive(1'b1, 4'b0010, 32'h3000_0010, 32'h0000_5500); settle();
    checks++; if (csb0 !== 1'b0 || web0 !== 1'b1 || core_stall !== 1'b1) begin errors++; $display("FAIL pw_n: got csb0=%b web0=%b stall=%b expected 0 1 1", csb0, web0, core_stall); end
    tick(); settle();
    checks++; if (core_stall !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL pw_wait: got stall=%b ack=%b expected 1 0", core_stall, ack); end
    tick(); settle();
    checks++; if (csb0 !== 1'b0 || web0 !== 1'b0 || core_stall !== 1'b1) begin errors++; $display("FAIL pw_merge_ctrl: got csb0=%b web0=%b stall=%b expected 0 0 1", csb0, web0, core_stall); end
    checks++; if (din0 !== 32'hDEAD_55EF) begin errors++; $display("FAIL pw_merge_din: got %h expected dead55ef", din0); end
    tick(); settle();
    checks++; if (ack !== 1'b1 || dat_o !== 32'h0) begin errors++; $display("FAIL pw_ack_n3: got ack=%b dat=%h expected 1 00000000", ack, dat_o); end
    tick(); wb_release(); settle();
    checks++; if (mem[4] !== 32'hDEAD_55EF) begin errors++; $display("FAIL pw_mem: got %h expected dead55ef", mem[4]); end
  endtask

  task automatic test_sel_zero();
    tick(); wb_drive(1'b1, 4'h0, 32'h3000_0010, 32'hFFFF_FFFF); settle();
    tick(); settle(); tick(); settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sel0_early: got %b expected 0", ack); end
    tick(); settle();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sel0_ack: got %b expected 1", ack); end
    tick(); wb_release(); settle();
    checks++; if (mem[4] !== 32'hDEAD_55EF) begin errors++; $display("FAIL sel0_mem: got %h expected dead55ef", mem[4]); end
  endtask

  task automatic test_miss();
    logic [31:0] miss_adr [2];
    miss_adr[0] = 32'h3000_0400;
    miss_adr[1] = 32'h2000_0000;
    for (int k = 0; k < 2; k++) begin
      int acks;
      int accs;
      acks = 0; accs = 0;
      tick(); wb_drive(1'b1, 4'hF, miss_adr[k], 32'hBAD0_BAD0);
      for (int c = 0; c < 10; c++) begin
        settle();
        if (ack !== 1'b0) acks++;
        if (csb0 !== 1'b1 || core_stall !== 1'b0) accs++;
        tick();
      end
      checks++; if (acks != 0) begin errors++; $display("FAIL miss_ack[%0d]: got %0d ack cycles expected 0", k, acks); end
      checks++; if (accs != 0) begin errors++; $display("FAIL miss_access[%0d]: got %0d access cycles expected 0", k, accs); end
      wb_release();
    end
  endtask

  task automatic test_cyc_drop();
    int wr;
    int ak;
    wr = 0; ak = 0;
    tick(); wb_drive(1'b1, 4'b0001, 32'h3000_0014, 32'h0000_00AA); settle();
    tick(); wb_release(); settle();
    for (int c = 0; c < 4; c++) begin
      if (csb0 === 1'b0 && web0 === 1'b0) wr++;
      if (ack !== 1'b0) ak++;
      tick(); settle();
    end
    checks++; if (wr != 0 || ak != 0) begin errors++; $display("FAIL drop_rdwait: got writes=%0d acks=%0d expected 0 0", wr, ak); end
    checks++; if (mem[5] !== 32'h1000_0005) begin errors++; $display("FAIL drop_mem: got %h expected 10000005", mem[5]); end
    tick(); wb_drive(1'b1, 4'hF, 32'h3000_0018, 32'h6666_6666); settle();
    tick(); wb_release(); settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL drop_ack: got %b expected 0", ack); end
    checks++; if (mem[6] !== 32'h6666_6666) begin errors++; $display("FAIL drop_ack_mem: got %h expected 66666666", mem[6]); end
  endtask

  task automatic test_reset_mid();
    int wr;
    int ak;
    wr = 0; ak = 0;
    tick(); wb_drive(1'b1, 4'b0001, 32'h3000_0014, 32'h0000_00FF); settle();
    tick(); settle();
    checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rmid_wait: got %b expected 1", core_stall); end
    #1;
    rst_n = 1'b0; wb_release(); core_csb = 1'b0; core_web = 1'b1; core_addr = 8'h77;
    #1;
    checks++; if (core_stall !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL rmid_stall_ack: got stall=%b ack=%b expected 0 0", core_stall, ack); end
    checks++; if (csb0 !== 1'b0 || addr0 !== 8'h77) begin errors++; $display("FAIL rmid_core_port: got csb0=%b addr0=%h expected 0 77", csb0, addr0); end
    tick(); rst_n = 1'b1; core_csb = 1'b1; settle();
    for (int c = 0; c < 5; c++) begin
      if (csb0 === 1'b0 && web0 === 1'b0) wr++;
      if (ack !== 1'b0) ak++;
      tick(); settle();
    end
    checks++; if (wr != 0 || ak != 0) begin errors++; $display("FAIL rmid_after: got writes=%0d acks=%0d expected 0 0", wr, ak); end
    checks++; if (mem[5] !== 32'h1000_0005) begin errors++; $display("FAIL rmid_mem: got %h expected 10000005", mem[5]); end
  endtask

  task automatic test_back_to_back();
    tick(); wb_drive(1'b1, 4'hF, 32'h3000_0020, 32'hA5A5_0F0F); settle();
    tick(); settle();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_wack: got %b expected 1", ack); end
    tick(); wb_drive(1'b0, 4'hF, 32'h3000_0020, 32'h0); settle();
    checks++; if (core_stall !== 1'b1 || csb0 !== 1'b0 || web0 !== 1'b1 || addr0 !== 8'h08) begin errors++; $display("FAIL b2b_accept: got stall=%b csb0=%b web0=%b addr0=%h expected 1 0 1 08", core_stall, csb0, web0, addr0); end
    tick(); settle();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b expected 0", ack); end
    tick(); settle();
    checks++; if (ack !== 1'b1 || dat_o !== 32'hA5A5_0F0F) begin errors++; $display("FAIL b2b_rack: got ack=%b dat=%h expected 1 a5a50f0f", ack, dat_o); end
    tick(); wb_release(); settle();
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_read_with_core();
    test_partial_write();
    test_sel_zero();
    test_miss();
    test_cyc_drop();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
